// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared FSM states and line levels for the shift-register serial link
package serial_link_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RECOVER} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in parallel-out shift register, MSB-first or LSB-first
module sipo_shift_reg #(
  parameter int n = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic [n-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= MSB_FIRST ? {q[n-2:0], d} : {d, q[n-1:1]};
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start/data/parity/stop deframer with a one-entry valid/ready output buffer
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int n = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit PARITY_EN = 1,
  parameter bit PARITY_ODD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_en,
  input  logic serial_in,
  output logic [n-1:0] data_out,
  output logic data_valid,
  input  logic data_ready,
  output logic parity_err,
  output logic frame_err,
  output logic overrun,
  output logic busy
);
  localparam int CW = $clog2(n + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [n-1:0] sr;
  logic par_bad, stop_edge, good;
  assign stop_edge = bit_en && state == STOP;
  assign good = stop_edge && serial_in == STOP_BIT && !par_bad;
  assign busy = state != IDLE;
  sipo_shift_reg #(.n(n), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk),
    .reset(reset),
    .en(bit_en && state == DATA),
    .d(serial_in),
    .q(sr)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    if (bit_en)
      case (state)
        IDLE:    nxt = serial_in == START_BIT ? DATA : IDLE;
        DATA:    nxt = cnt == CW'(n - 1) ? (PARITY_EN ? PARITY : STOP) : DATA;
        PARITY:  nxt = STOP;
        STOP:    nxt = serial_in == STOP_BIT ? IDLE : RECOVER;
        RECOVER: nxt = serial_in == IDLE_LEVEL ? IDLE : RECOVER;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      par_bad <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      parity_err <= stop_edge && serial_in == STOP_BIT && par_bad;
      frame_err <= stop_edge && serial_in != STOP_BIT;
      overrun <= good && data_valid && !data_ready;
      if (bit_en && state == IDLE) begin
        cnt <= '0;
        par_bad <= 1'b0;
      end else if (bit_en && state == DATA && cnt != CW'(n)) cnt <= cnt + 1'b1;
      if (bit_en && state == PARITY) par_bad <= ^{sr, serial_in, PARITY_ODD};
      if (good && (!data_valid || data_ready)) begin
        data_out <= sr;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: table-driven and directed checks of the frame receiver
module tb_serial_frame_receiver;
  logic clk = 0, reset = 1, bit_en = 1, serial_in = 1, data_ready = 0;
  logic [7:0] data_out;
  logic data_valid, parity_err, frame_err, overrun, busy;
  logic bit_en_l = 0, serial_l = 1, ready_l = 0;
  logic [7:0] data_out_l;
  logic valid_l, perr_l, ferr_l, ovr_l, busy_l;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  serial_frame_receiver #(.n(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  serial_frame_receiver #(.n(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) dut_l (
    .clk(clk), .reset(reset), .bit_en(bit_en_l), .serial_in(serial_l),
    .data_out(data_out_l), .data_valid(valid_l), .data_ready(ready_l),
    .parity_err(perr_l), .frame_err(ferr_l), .overrun(ovr_l), .busy(busy_l)
  );
  typedef struct {
    logic [7:0] word;
    bit flip, rdy, acc, v;
    logic [7:0] d;
    bit pe, fe, ov;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic line(input logic b);
    serial_in = b;
    tick();
  endtask
  task automatic send(input logic [7:0] w, input bit flip, input logic stop, input bit rdy);
    line(1'b0);
    chk("busy_rise", busy, 1);
    for (int i = 7; i >= 0; i--) line(w[i]);
    line(^w ^ flip);
    data_ready = rdy;
    line(stop);
    data_ready = 0;
  endtask
  initial begin
    logic [7:0] w;
    logic [10:0] bl;
    int bc;
    vecs[0] = '{8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0, 0};
    vecs[1] = '{8'hA5, 1, 0, 1, 0, 8'hA5, 1, 0, 0};
    vecs[2] = '{8'h3C, 0, 0, 0, 1, 8'h3C, 0, 0, 0};
    vecs[3] = '{8'h11, 0, 0, 1, 1, 8'h11, 0, 0, 0};
    vecs[4] = '{8'h22, 0, 0, 0, 1, 8'h11, 0, 0, 1};
    vecs[5] = '{8'h22, 0, 1, 0, 1, 8'h22, 0, 0, 0};
    vecs[6] = '{8'hFF, 0, 0, 1, 1, 8'hFF, 0, 0, 0};
    vecs[7] = '{8'h00, 0, 0, 1, 1, 8'h00, 0, 0, 0};
    tick();
    tick();
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 0;
    line(1);
    line(1);
    foreach (vecs[i]) begin
      if (vecs[i].acc) begin
        data_ready = 1;
        line(1);
        data_ready = 0;
        chk("accept", data_valid, 0);
      end
      send(vecs[i].word, vecs[i].flip, 1'b1, vecs[i].rdy);
      chk("valid", data_valid, vecs[i].v);
      chk("data", data_out, vecs[i].d);
      chk("perr", parity_err, vecs[i].pe);
      chk("ferr", frame_err, vecs[i].fe);
      chk("ovr", overrun, vecs[i].ov);
      line(1);
      chk("pulse_clear", {parity_err, frame_err, overrun}, 0);
      chk("busy_idle", busy, 0);
      chk("hold", data_valid, vecs[i].v);
    end
    data_ready = 1;
    line(1);
    data_ready = 0;
    send(8'hA5, 0, 1'b0, 0);
    chk("fe_pulse", frame_err, 1);
    chk("fe_perr", parity_err, 0);
    chk("fe_busy", busy, 1);
    chk("fe_valid", data_valid, 0);
    repeat (3) begin
      line(0);
      chk("brk_busy", busy, 1);
      chk("brk_fe_low", frame_err, 0);
    end
    line(1);
    chk("rec_exit", busy, 0);
    repeat (10) line(1);
    chk("no_false_start", {busy, data_valid}, 0);
    send(8'h3C, 0, 1'b1, 0);
    chk("after_fe_valid", data_valid, 1);
    chk("after_fe_data", data_out, 8'h3C);
    line(1);
    line(0);
    line(1);
    line(0);
    line(1);
    line(1);
    reset = 1;
    tick();
    chk("mrst_data", data_out, 0);
    chk("mrst_valid", data_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_errs", {parity_err, frame_err, overrun}, 0);
    reset = 0;
    line(1);
    send(8'hFF, 0, 1'b1, 0);
    chk("mrst_next_valid", data_valid, 1);
    chk("mrst_next_data", data_out, 8'hFF);
    w = 8'h5A;
    bl[0] = 1'b0;
    for (int i = 0; i < 8; i++) bl[1+i] = w[i];
    bl[9] = ^w;
    bl[10] = 1'b1;
    bc = 0;
    for (int k = 0; k < 11; k++) begin
      serial_l = bl[k];
      for (int c = 0; c < 4; c++) begin
        bit_en_l = c == 3;
        tick();
        bc += int'(busy_l);
      end
    end
    bit_en_l = 0;
    serial_l = 1;
    repeat (4) begin
      tick();
      bc += int'(busy_l);
    end
    chk("lsb_busy_span", bc, 40);
    chk("lsb_data", data_out_l, 8'h5A);
    chk("lsb_valid", valid_l, 1);
    chk("lsb_errs", {perr_l, ferr_l, ovr_l}, 0);
    ready_l = 1;
    tick();
    ready_l = 0;
    chk("lsb_accept", valid_l, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
